// File: rtl/dispensador_ctrl.sv
// Purpose: vend-output sequencer -- drives one slot-motor pulse, then N coin-return pulses, each followed by an idle gap, then a done strobe.
// Latency: first pulse (or done when nothing to dispense) appears the cycle after the accepting listo edge; all outputs registered.
// Backpressure: none; a listo edge while busy is dropped and raises the sticky ovr flag.
//
// Ports:
//   clk         clock, rising edge
//   rst_n       synchronous active-low reset
//   listo       vend-complete strobe/level; a 0->1 transition is a request
//   producto    product slot code (0 = none, 1..3 = slot)
//   cambio      number of change coins to return (0..3)
//   motor       one-hot slot motor drive
//   coin_pulse  coin-return solenoid pulse
//   busy        high whenever the sequencer is not idle
//   done        one-cycle completion strobe
//   ovr         sticky overrun flag (request seen while busy)
module dispensador_ctrl #(
  parameter int PULSE_CYC = 4,
  parameter int GAP_CYC   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       listo,
  input  logic [1:0] producto,
  input  logic [1:0] cambio,
  output logic [2:0] motor,
  output logic       coin_pulse,
  output logic       busy,
  output logic       done,
  output logic       ovr
);

  localparam logic [7:0] PULSE_LAST = 8'(PULSE_CYC - 1);
  localparam logic [7:0] GAP_LAST   = 8'(GAP_CYC - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MOTOR = 3'd1,
    GAP   = 3'd2,
    COIN  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t     state, state_nxt;
  logic       listo_q;
  logic [1:0] prod_q, prod_nxt;
  logic [7:0] coins_q, coins_nxt;
  logic [7:0] cnt, cnt_nxt;

  logic       req;
  logic       accept;

  logic [2:0] motor_nxt;
  logic       coin_nxt;
  logic       busy_nxt;
  logic       done_nxt;
  logic       ovr_nxt;

  assign req    = listo & ~listo_q;
  assign accept = req && (state == IDLE);

  // State, counters, latched request and registered outputs.
  // listo_q resets high so a level held across reset release is not a request.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      listo_q    <= 1'b1;
      prod_q     <= 2'd0;
      coins_q    <= 8'd0;
      cnt        <= 8'd0;
      motor      <= 3'd0;
      coin_pulse <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      ovr        <= 1'b0;
    end else begin
      state      <= state_nxt;
      listo_q    <= listo;
      prod_q     <= prod_nxt;
      coins_q    <= coins_nxt;
      cnt        <= cnt_nxt;
      motor      <= motor_nxt;
      coin_pulse <= coin_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      ovr        <= ovr_nxt;
    end
  end

  // Next-state logic. cnt counts cycles spent in the current timed state.
  always_comb begin
    state_nxt = state;
    prod_nxt  = prod_q;
    coins_nxt = coins_q;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          prod_nxt  = producto;
          coins_nxt = {6'd0, cambio};
          cnt_nxt   = 8'd0;
          if (producto != 2'd0)    state_nxt = MOTOR;
          else if (cambio != 2'd0) state_nxt = COIN;
          else                     state_nxt = DONE;
        end
      end
      MOTOR: begin
        if (cnt == PULSE_LAST) begin
          state_nxt = GAP;
          cnt_nxt   = 8'd0;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      COIN: begin
        if (cnt == PULSE_LAST) begin
          state_nxt = GAP;
          cnt_nxt   = 8'd0;
          coins_nxt = coins_q - 8'd1;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_nxt   = 8'd0;
          state_nxt = (coins_q != 8'd0) ? COIN : DONE;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
        cnt_nxt   = 8'd0;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 8'd0;
      end
    endcase
  end

  // Output decode from the upcoming state so the registered outputs line up
  // with the state they describe (no input-to-output combinational path).
  always_comb begin
    motor_nxt = 3'd0;
    if (state_nxt == MOTOR) begin
      case (prod_nxt)
        2'd1:    motor_nxt = 3'b001;
        2'd2:    motor_nxt = 3'b010;
        2'd3:    motor_nxt = 3'b100;
        default: motor_nxt = 3'b000;
      endcase
    end
    coin_nxt = (state_nxt == COIN);
    busy_nxt = (state_nxt != IDLE);
    done_nxt = (state_nxt == DONE);
    ovr_nxt  = ovr | (req && (state != IDLE));
  end

endmodule

// File: tb/tb_dispensador_ctrl.sv
module tb_dispensador_ctrl;

  localparam int P = 4;
  localparam int G = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       listo;
  logic [1:0] producto;
  logic [1:0] cambio;
  logic [2:0] motor;
  logic       coin_pulse;
  logic       busy;
  logic       done;
  logic       ovr;

  int checks = 0;
  int errors = 0;

  dispensador_ctrl #(.PULSE_CYC(P), .GAP_CYC(G)) dut (
    .clk(clk), .rst_n(rst_n), .listo(listo), .producto(producto), .cambio(cambio),
    .motor(motor), .coin_pulse(coin_pulse), .busy(busy), .done(done), .ovr(ovr)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // Each accepted vend expands into a per-cycle list of expected output
  // vectors {motor[2:0], coin, busy, done}; one vector is consumed per cycle.
  logic [5:0] sched[$];
  logic [5:0] exp_vec  = 6'd0;
  logic       exp_ovr  = 1'b0;
  logic       lprev    = 1'b1;
  bit         model_ok = 0;

  task automatic build_sched(input logic [1:0] p, input logic [1:0] c);
    logic [2:0] oh;
    oh = 3'b001 << (p - 2'd1);
    if (p != 0) begin
      repeat (P) sched.push_back({oh, 1'b0, 1'b1, 1'b0});
      repeat (G) sched.push_back(6'b000_0_1_0);
    end
    for (int i = 0; i < int'(c); i++) begin
      repeat (P) sched.push_back(6'b000_1_1_0);
      repeat (G) sched.push_back(6'b000_0_1_0);
    end
    sched.push_back(6'b000_0_1_1);
  endtask

  always @(posedge clk) begin
    logic rq;
    model_ok = 1;
    if (!rst_n) begin
      sched.delete();
      exp_vec = 6'd0;
      exp_ovr = 1'b0;
      lprev   = 1'b1;
    end else begin
      rq    = listo && !lprev;
      lprev = listo;
      if (rq) begin
        if (exp_vec[1] == 1'b0) build_sched(producto, cambio);
        else                    exp_ovr = 1'b1;
      end
      if (sched.size() > 0) exp_vec = sched.pop_front();
      else                  exp_vec = 6'd0;
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (model_ok) begin
      checks++;
      if ({motor, coin_pulse, busy, done, ovr} !== {exp_vec, exp_ovr}) begin
        errors++;
        $display("FAIL cycle_compare t=%0t actual motor=%b coin=%b busy=%b done=%b ovr=%b required motor=%b coin=%b busy=%b done=%b ovr=%b",
                 $time, motor, coin_pulse, busy, done, ovr,
                 exp_vec[5:3], exp_vec[2], exp_vec[1], exp_vec[0], exp_ovr);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  logic [2:0] mot[0:31];
  logic       cp[0:31];
  logic       bs[0:31];
  logic       dn[0:31];
  logic       ov[0:31];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Called at a negedge: raises listo in this cycle (cycle k) and captures the
  // outputs of cycles k+1..k+n. retrig>0 re-raises listo in cycle k+retrig;
  // with retrig==0 the product/change inputs are scrambled after acceptance.
  task automatic run_vend(input logic [1:0] p, input logic [1:0] c, input int retrig, input int n);
    producto = p;
    cambio   = c;
    listo    = 1'b1;
    for (int j = 1; j <= n; j++) begin
      @(negedge clk);
      mot[j] = motor; cp[j] = coin_pulse; bs[j] = busy; dn[j] = done; ov[j] = ovr;
      if (j == 1) begin
        listo = 1'b0;
        if (retrig == 0) begin
          producto = ~p;
          cambio   = 2'd3;
        end
      end
      if (retrig != 0 && j == retrig - 1) listo = 1'b0;
      if (retrig != 0 && j == retrig)     listo = 1'b1;
    end
    listo = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    rst_n    = 1'b0;
    listo    = 1'b0;
    producto = 2'd0;
    cambio   = 2'd0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {3'd0, motor, coin_pulse, busy, done, ovr}, 8'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // product 2, no change
    run_vend(2'd2, 2'd0, 0, 10);
    chk("p2_motor_k1", {5'd0, mot[1]}, 8'b010);
    chk("p2_motor_k4", {5'd0, mot[4]}, 8'b010);
    chk("p2_gap_k5",   {5'd0, mot[5]}, 8'd0);
    chk("p2_done_k6",  {7'd0, dn[6]},  8'd0);
    chk("p2_done_k7",  {7'd0, dn[7]},  8'd1);
    chk("p2_busy_k7",  {7'd0, bs[7]},  8'd1);
    chk("p2_busy_k8",  {7'd0, bs[8]},  8'd0);

    // product 1, two coins
    run_vend(2'd1, 2'd2, 0, 21);
    chk("p1c2_motor_k1", {5'd0, mot[1]}, 8'b001);
    chk("p1c2_coin_k7",  {7'd0, cp[7]},  8'd1);
    chk("p1c2_coin_k10", {7'd0, cp[10]}, 8'd1);
    chk("p1c2_coin_k11", {7'd0, cp[11]}, 8'd0);
    chk("p1c2_coin_k13", {7'd0, cp[13]}, 8'd1);
    chk("p1c2_coin_k16", {7'd0, cp[16]}, 8'd1);
    chk("p1c2_done_k19", {7'd0, dn[19]}, 8'd1);

    // change only
    run_vend(2'd0, 2'd1, 0, 9);
    chk("c1_motor_k1", {5'd0, mot[1]}, 8'd0);
    chk("c1_coin_k1",  {7'd0, cp[1]},  8'd1);
    chk("c1_coin_k4",  {7'd0, cp[4]},  8'd1);
    chk("c1_done_k7",  {7'd0, dn[7]},  8'd1);

    // nothing to dispense, re-request on the idle cycle right after done
    run_vend(2'd0, 2'd0, 2, 6);
    chk("empty_done_k1", {7'd0, dn[1]}, 8'd1);
    chk("empty_busy_k1", {7'd0, bs[1]}, 8'd1);
    chk("empty_busy_k2", {7'd0, bs[2]}, 8'd0);
    chk("reacc_done_k3", {7'd0, dn[3]}, 8'd1);
    chk("reacc_ovr_k4",  {7'd0, ov[4]}, 8'd0);

    // overrun: second edge in the middle of a product-3 vend
    run_vend(2'd3, 2'd0, 3, 12);
    chk("ovr_motor_k1", {5'd0, mot[1]}, 8'b100);
    chk("ovr_ovr_k3",   {7'd0, ov[3]},  8'd0);
    chk("ovr_ovr_k4",   {7'd0, ov[4]},  8'd1);
    chk("ovr_done_k7",  {7'd0, dn[7]},  8'd1);
    chk("ovr_busy_k9",  {7'd0, bs[9]},  8'd0);
    chk("ovr_held_k12", {7'd0, ov[12]}, 8'd1);

    // reset in the middle of a vend with listo held high
    producto = 2'd1;
    cambio   = 2'd3;
    listo    = 1'b1;
    @(negedge clk);
    chk("rst_motor_k1", {5'd0, motor}, 8'b001);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_abort_outs", {3'd0, motor, coin_pulse, busy, done, ovr}, 8'd0);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("rst_held_busy", {7'd0, busy}, 8'd0);
    listo = 1'b0;
    @(negedge clk);
    run_vend(2'd2, 2'd0, 0, 9);
    chk("post_rst_motor_k1", {5'd0, mot[1]}, 8'b010);
    chk("post_rst_done_k7",  {7'd0, dn[7]},  8'd1);

    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dispensador_ctrl.md
DISPENSADOR_CTRL -- requirements
Module: dispensador_ctrl

Interface
REQ-001 Parameter PULSE_CYC, default 4, active-pulse length in clk cycles (legal 1..255).
REQ-002 Parameter GAP_CYC, default 2, idle gap length in clk cycles after every pulse (legal 1..255).
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 listo  input  1  vend-complete strobe/level from the vending FSM.
REQ-006 producto  input  2  product code; 0 = no product, 1..3 = slot.
REQ-007 cambio  input  2  number of change coins to return, 0..3.
REQ-008 motor  output  3  one-hot slot motor drive; bit (producto-1) active.
REQ-009 coin_pulse  output  1  coin-return solenoid pulse.
REQ-010 busy  output  1  high whenever state is not IDLE.
REQ-011 done  output  1  single-cycle completion strobe.
REQ-012 ovr  output  1  sticky overrun flag.

Function
REQ-013 The block SHALL register listo into listo_q each cycle and detect a request as listo=1 and listo_q=0.
REQ-014 A request SHALL be accepted only in IDLE; on acceptance producto and cambio SHALL be latched into internal registers on that same edge.
REQ-015 States SHALL be IDLE, MOTOR, GAP, COIN, DONE; all counters 8 bits wide.
REQ-016 On acceptance with latched producto!=0 the next state SHALL be MOTOR; else with cambio!=0, COIN; else DONE.
REQ-017 MOTOR SHALL last exactly PULSE_CYC cycles with motor one-hot per latched producto, then go to GAP.
REQ-018 COIN SHALL last exactly PULSE_CYC cycles with coin_pulse=1, decrement the latched coin count by 1 on exit, then go to GAP.
REQ-019 GAP SHALL last exactly GAP_CYC cycles with motor=0 and coin_pulse=0, then go to COIN if remaining coins >0, else DONE.
REQ-020 DONE SHALL last exactly one cycle with done=1, then go to IDLE.
REQ-021 motor and coin_pulse SHALL never be active simultaneously; outputs SHALL be registered (no combinational path from inputs).
REQ-022 A request edge detected while not IDLE (including the DONE cycle) SHALL be ignored and SHALL set ovr=1; ovr SHALL remain 1 until reset.
REQ-023 A request edge coinciding with the IDLE cycle right after DONE SHALL be accepted normally.
REQ-024 Changes to producto/cambio after acceptance SHALL not affect the operation in progress.
REQ-025 Latency: first pulse cycle (or done, if nothing to dispense) SHALL be the cycle immediately after the acceptance edge.

Reset
REQ-026 With rst_n=0 at a rising edge: state=IDLE, motor=0, coin_pulse=0, busy=0, done=0, ovr=0, counters=0, latched registers=0.
REQ-027 listo_q SHALL reset to 1, so listo held high across reset release is not a request; a fresh 0->1 transition is required.
REQ-028 Reset asserted mid-operation SHALL abort immediately at that edge with no done strobe and no further pulses.

Verification (defaults PULSE_CYC=4, GAP_CYC=2; accept edge = cycle k)
REQ-029 producto=2, cambio=0 -> motor=3'b010 cycles k+1..k+4, all low k+5..k+6, done=1 at k+7, busy=1 k+1..k+7.
REQ-030 producto=1, cambio=2 -> motor=3'b001 k+1..k+4; coin_pulse k+7..k+10 and k+13..k+16; done at k+19.
REQ-031 producto=0, cambio=1 -> motor stays 0, coin_pulse k+1..k+4, done at k+7; producto=0, cambio=0 -> done at k+1, busy only at k+1.
REQ-032 listo toggled 0->1 again at k+3 of a producto=3 vend -> vend completes unchanged (done at k+7), ovr=1 and held; no second vend.
REQ-033 rst_n=0 at k+2 of a producto=1, cambio=3 vend with listo held high -> all outputs 0 from that edge, no done; after release no vend until listo drops and rises again.
